// File: rtl/strela_exec_ctrl.sv
// strela_exec_ctrl: run sequencer between the CGRA CSR block and the CGRA/DMA
// datapath. Turns load/start/clear command pulses into an ordered
// config-load / execute / clear sequence, tracks per-output-node completion,
// and keeps saturating load/execute/stall cycle counters.
//
// Optional feature: define STRELA_EXEC_IRQ_EN to build the completion
// interrupt register (irq_o / irq_ack_i); otherwise irq_o is tied low.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   load_configuration_i          command pulse: load configuration
//   start_execution_i             command pulse: start execution
//   clear_cgra_i                  command pulse: abort and clear (any state)
//   out_enable_i                  active output nodes, sampled at start accept
//   cfg_start_o / cfg_done_i      config DMA start pulse / completion pulse
//   exec_start_o / out_done_i     execution start pulse / per-node completion
//   stall_i                       datapath backpressure this cycle
//   done_config_o                 level: last config load complete
//   done_exec_output_o            level: last execution complete
//   cgra_reset_o                  synchronous clear to the CGRA fabric
//   busy_o                        sequencer not idle
//   cycle_count_*_o               load-config / execute / stall cycle counters
//   irq_o / irq_ack_i             completion interrupt / acknowledge
module strela_exec_ctrl #(
    parameter int unsigned OUTPUT_NODES_NUM = 4,
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned CLEAR_CYCLES     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        load_configuration_i,
    input  logic                        start_execution_i,
    input  logic                        clear_cgra_i,
    input  logic [OUTPUT_NODES_NUM-1:0] out_enable_i,
    output logic                        cfg_start_o,
    input  logic                        cfg_done_i,
    output logic                        exec_start_o,
    input  logic [OUTPUT_NODES_NUM-1:0] out_done_i,
    input  logic                        stall_i,
    output logic                        done_config_o,
    output logic                        done_exec_output_o,
    output logic                        cgra_reset_o,
    output logic                        busy_o,
    output logic [CNT_W-1:0]            cycle_count_load_config_o,
    output logic [CNT_W-1:0]            cycle_count_execute_o,
    output logic [CNT_W-1:0]            cycle_count_stall_o,
    output logic                        irq_o,
    input  logic                        irq_ack_i
);

    localparam int unsigned CLR_W   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_EXEC  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    state_e                      state_q;
    logic [OUTPUT_NODES_NUM-1:0] mask_q;
    logic [CLR_W-1:0]            clr_cnt_q;
    logic                        cfg_start_q;
    logic                        exec_start_q;
    logic                        done_config_q;
    logic                        done_exec_q;
    logic                        cgra_reset_q;
    logic                        busy_q;
    logic [CNT_W-1:0]            cnt_load_q;
    logic [CNT_W-1:0]            cnt_exec_q;
    logic [CNT_W-1:0]            cnt_stall_q;

    // Nodes still outstanding once this cycle's completions are applied.
    logic [OUTPUT_NODES_NUM-1:0] mask_left;
    assign mask_left = mask_q & ~out_done_i;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Sequencer: clear pre-empts everything; load/start only accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            clr_cnt_q     <= '0;
            cfg_start_q   <= 1'b0;
            exec_start_q  <= 1'b0;
            done_config_q <= 1'b0;
            done_exec_q   <= 1'b0;
            cgra_reset_q  <= 1'b0;
            busy_q        <= 1'b0;
            cnt_load_q    <= '0;
            cnt_exec_q    <= '0;
            cnt_stall_q   <= '0;
        end else begin
            cfg_start_q  <= 1'b0;
            exec_start_q <= 1'b0;
            if (clear_cgra_i) begin
                state_q       <= ST_CLEAR;
                busy_q        <= 1'b1;
                cgra_reset_q  <= 1'b1;
                clr_cnt_q     <= CLR_W'(CLEAR_CYCLES - 1);
                mask_q        <= '0;
                done_config_q <= 1'b0;
                done_exec_q   <= 1'b0;
                cnt_load_q    <= '0;
                cnt_exec_q    <= '0;
                cnt_stall_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (load_configuration_i) begin
                            state_q       <= ST_CFG;
                            busy_q        <= 1'b1;
                            cfg_start_q   <= 1'b1;
                            done_config_q <= 1'b0;
                            cnt_load_q    <= '0;
                        end else if (start_execution_i) begin
                            mask_q      <= out_enable_i;
                            cnt_exec_q  <= '0;
                            cnt_stall_q <= '0;
                            // An empty run completes immediately without touching the datapath.
                            if (out_enable_i == '0) begin
                                done_exec_q <= 1'b1;
                            end else begin
                                done_exec_q  <= 1'b0;
                                state_q      <= ST_EXEC;
                                busy_q       <= 1'b1;
                                exec_start_q <= 1'b1;
                            end
                        end
                    end
                    ST_CFG: begin
                        cnt_load_q <= sat_inc(cnt_load_q);
                        if (cfg_done_i) begin
                            state_q       <= ST_IDLE;
                            busy_q        <= 1'b0;
                            done_config_q <= 1'b1;
                        end
                    end
                    ST_EXEC: begin
                        cnt_exec_q <= sat_inc(cnt_exec_q);
                        if (stall_i) begin
                            cnt_stall_q <= sat_inc(cnt_stall_q);
                        end
                        mask_q <= mask_left;
                        if (mask_left == '0) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            done_exec_q <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (clr_cnt_q == '0) begin
                            state_q      <= ST_IDLE;
                            busy_q       <= 1'b0;
                            cgra_reset_q <= 1'b0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q - CLR_W'(1);
                        end
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        cgra_reset_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_start_o               = cfg_start_q;
    assign exec_start_o              = exec_start_q;
    assign done_config_o             = done_config_q;
    assign done_exec_output_o        = done_exec_q;
    assign cgra_reset_o              = cgra_reset_q;
    assign busy_o                    = busy_q;
    assign cycle_count_load_config_o = cnt_load_q;
    assign cycle_count_execute_o     = cnt_exec_q;
    assign cycle_count_stall_o       = cnt_stall_q;

`ifdef STRELA_EXEC_IRQ_EN
    logic irq_q;
    logic done_rise;

    // Same-edge detection of either done flag going 0->1.
    assign done_rise = !clear_cgra_i && (
        ((state_q == ST_CFG)  && cfg_done_i) ||
        ((state_q == ST_EXEC) && (mask_left == '0)) ||
        ((state_q == ST_IDLE) && !load_configuration_i && start_execution_i &&
         (out_enable_i == '0) && !done_exec_q));

    // Set wins over a coincident acknowledge; clear accept always drops it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else if (clear_cgra_i) begin
            irq_q <= 1'b0;
        end else if (done_rise) begin
            irq_q <= 1'b1;
        end else if (irq_ack_i) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack_i;
    assign irq_o          = 1'b0;
`endif

endmodule
